// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount datapath and its testbenches.
//   state_t            : packet framing FSM states
//   cnt_width(width)   : width of one word's popcount
//   sum_width(mw, w)   : width of a packet sum of up to mw words of w bits
//   len_width(mw)      : width of a word count up to mw
package popcount_pkg;

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int sum_width(input int max_words, input int width);
    return $clog2(max_words * width + 1);
  endfunction

  function automatic int len_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/popcount_packet_accumulator.sv
// Sums per-word popcounts over an sop/eop framed packet, counts its words and
// presents one result per packet on a valid/ready output. Input is never
// stalled; a finished result that finds the output register occupied is
// dropped and flagged.
// Ports:
//   clk          clock, posedge
//   arst_n_i     asynchronous active-low reset
//   cnt_i        popcount of one word
//   cnt_val_i    cnt_i valid; qualifies cnt_sop_i / cnt_eop_i
//   cnt_sop_i    first word of packet
//   cnt_eop_i    last word of packet
//   sum_o        total ones in packet
//   len_o        words accumulated
//   sat_o        packet exceeded MAX_WORDS, sum/len are partial
//   sum_val_o    result valid, held until sum_ready_i
//   sum_ready_i  consumer accepts result
//   err_o        one-cycle framing error pulse
//   drop_o       one-cycle lost-result pulse
module popcount_packet_accumulator
  import popcount_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 256,
  localparam int CNT_W    = cnt_width(WIDTH),
  localparam int SUM_W    = sum_width(MAX_WORDS, WIDTH),
  localparam int LEN_W    = len_width(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             arst_n_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cnt_val_i,
  input  logic             cnt_sop_i,
  input  logic             cnt_eop_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [LEN_W-1:0] len_o,
  output logic             sat_o,
  output logic             sum_val_o,
  input  logic             sum_ready_i,
  output logic             err_o,
  output logic             drop_o
);

  state_t             state, nxt_state;
  logic [SUM_W-1:0]   acc, nxt_acc, res_sum;
  logic [LEN_W-1:0]   len, nxt_len, res_len;
  logic               sat, nxt_sat, res_sat;
  logic               done, frame_err, load_ok;

  function automatic logic [SUM_W-1:0] add_cnt(input logic [SUM_W-1:0] a,
                                               input logic [CNT_W-1:0] c);
    return a + SUM_W'(c);
  endfunction

  function automatic logic at_limit(input logic [LEN_W-1:0] l);
    return l == LEN_W'(MAX_WORDS);
  endfunction

  // Framing FSM and accumulator next-state
  always_comb begin
    nxt_state = state;
    nxt_acc   = acc;
    nxt_len   = len;
    nxt_sat   = sat;
    done      = 1'b0;
    frame_err = 1'b0;
    res_sum   = '0;
    res_len   = '0;
    res_sat   = 1'b0;
    if (cnt_val_i) begin
      if (cnt_sop_i) begin
        // sop always restarts; inside ACCUM it also abandons the old packet
        frame_err = (state == ACCUM);
        nxt_acc   = SUM_W'(cnt_i);
        nxt_len   = LEN_W'(1);
        nxt_sat   = 1'b0;
        nxt_state = cnt_eop_i ? IDLE : ACCUM;
      end else if (state == IDLE) begin
        frame_err = 1'b1;
      end else begin
        // beyond MAX_WORDS the sums freeze and the sticky flag is raised
        if (at_limit(len)) begin
          nxt_sat = 1'b1;
        end else begin
          nxt_acc = add_cnt(acc, cnt_i);
          nxt_len = len + LEN_W'(1);
        end
        if (cnt_eop_i) nxt_state = IDLE;
      end
      if (cnt_eop_i && (cnt_sop_i || state == ACCUM)) begin
        done    = 1'b1;
        res_sum = nxt_acc;
        res_len = nxt_len;
        res_sat = nxt_sat;
      end
    end
  end

  // A held result frees up in the same cycle it is accepted, so load then.
  assign load_ok = !sum_val_o || sum_ready_i;

  // Stage boundary: packet state and output register
  always_ff @(posedge clk or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state     <= IDLE;
      acc       <= '0;
      len       <= '0;
      sat       <= 1'b0;
      sum_o     <= '0;
      len_o     <= '0;
      sat_o     <= 1'b0;
      sum_val_o <= 1'b0;
      err_o     <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      state  <= nxt_state;
      acc    <= nxt_acc;
      len    <= nxt_len;
      sat    <= nxt_sat;
      err_o  <= frame_err;
      drop_o <= done && !load_ok;
      if (done && load_ok) begin
        sum_o     <= res_sum;
        len_o     <= res_len;
        sat_o     <= res_sat;
        sum_val_o <= 1'b1;
      end else if (sum_ready_i) begin
        sum_val_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_packet_accumulator.sv
// Directed bench for popcount_packet_accumulator: a default instance
// (WIDTH=16, MAX_WORDS=256) and a small one (MAX_WORDS=4) for saturation.
module tb_popcount_packet_accumulator;
  import popcount_pkg::*;

  localparam int CNT_W  = cnt_width(16);
  localparam int SUM_W  = sum_width(256, 16);
  localparam int LEN_W  = len_width(256);
  localparam int SUM4_W = sum_width(4, 16);
  localparam int LEN4_W = len_width(4);

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CNT_W-1:0] cnt = '0;
  logic val = 1'b0, sop = 1'b0, eop = 1'b0, ready = 1'b0;
  logic [SUM_W-1:0] sum;
  logic [LEN_W-1:0] len;
  logic sat, sum_val, err, drop;

  logic [CNT_W-1:0] cnt4 = '0;
  logic val4 = 1'b0, sop4 = 1'b0, eop4 = 1'b0, ready4 = 1'b1;
  logic [SUM4_W-1:0] sum4;
  logic [LEN4_W-1:0] len4;
  logic sat4, sum_val4, err4, drop4;

  int n_cmp = 0;
  int n_bad = 0;

  popcount_packet_accumulator #(.WIDTH(16), .MAX_WORDS(256)) dut (
    .clk(clk), .arst_n_i(arst_n), .cnt_i(cnt), .cnt_val_i(val),
    .cnt_sop_i(sop), .cnt_eop_i(eop), .sum_o(sum), .len_o(len), .sat_o(sat),
    .sum_val_o(sum_val), .sum_ready_i(ready), .err_o(err), .drop_o(drop)
  );

  popcount_packet_accumulator #(.WIDTH(16), .MAX_WORDS(4)) dut4 (
    .clk(clk), .arst_n_i(arst_n), .cnt_i(cnt4), .cnt_val_i(val4),
    .cnt_sop_i(sop4), .cnt_eop_i(eop4), .sum_o(sum4), .len_o(len4),
    .sat_o(sat4), .sum_val_o(sum_val4), .sum_ready_i(ready4), .err_o(err4),
    .drop_o(drop4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One beat on the main instance; returns at the negedge after the edge
  // that sampled it, so registered outputs reflect that beat.
  task automatic beat(input logic s, input logic e, input int c);
    val = 1'b1; sop = s; eop = e; cnt = CNT_W'(c);
    @(posedge clk);
    @(negedge clk);
    val = 1'b0; sop = 1'b0; eop = 1'b0; cnt = '0;
  endtask

  task automatic beat4(input logic s, input logic e, input int c);
    val4 = 1'b1; sop4 = s; eop4 = e; cnt4 = CNT_W'(c);
    @(posedge clk);
    @(negedge clk);
    val4 = 1'b0; sop4 = 1'b0; eop4 = 1'b0; cnt4 = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_val", sum_val, 0);
    chk("rst_sum", sum, 0);
    chk("rst_len", len, 0);
    chk("rst_err", err, 0);
    chk("rst_drop", drop, 0);
    arst_n = 1'b1;
    idle(1);

    // 1: single-beat packet
    ready = 1'b1;
    beat(1, 1, 5);
    chk("t1_val", sum_val, 1);
    chk("t1_sum", sum, 5);
    chk("t1_len", len, 1);
    chk("t1_sat", sat, 0);
    idle(1);
    chk("t1_val_fall", sum_val, 0);

    // 2: three beats 16,0,7, held until ready
    ready = 1'b0;
    beat(1, 0, 16);
    chk("t2_mid_val", sum_val, 0);
    beat(0, 0, 0);
    beat(0, 1, 7);
    chk("t2_val", sum_val, 1);
    chk("t2_sum", sum, 23);
    chk("t2_len", len, 3);
    idle(1);
    chk("t2_held_val", sum_val, 1);
    chk("t2_held_sum", sum, 23);
    ready = 1'b1;
    idle(1);
    chk("t2_val_fall", sum_val, 0);

    // 3: A held, B dropped
    ready = 1'b0;
    beat(1, 0, 4);
    beat(0, 1, 5);
    chk("t3_a_sum", sum, 9);
    chk("t3_a_len", len, 2);
    beat(1, 0, 1);
    beat(0, 1, 2);
    chk("t3_drop", drop, 1);
    chk("t3_keep_sum", sum, 9);
    chk("t3_keep_len", len, 2);
    chk("t3_keep_val", sum_val, 1);
    idle(1);
    chk("t3_drop_pulse", drop, 0);

    // 3b: A still held, B completes in the accepting cycle
    beat(1, 0, 1);
    ready = 1'b1;
    beat(0, 1, 2);
    chk("t3b_drop", drop, 0);
    chk("t3b_val", sum_val, 1);
    chk("t3b_sum", sum, 3);
    chk("t3b_len", len, 2);
    idle(1);
    chk("t3b_val_fall", sum_val, 0);

    // 4: framing errors
    beat(0, 0, 3);
    chk("t4_idle_err", err, 1);
    chk("t4_idle_noval", sum_val, 0);
    beat(1, 0, 8);
    chk("t4_err_clear", err, 0);
    beat(0, 0, 2);
    beat(1, 0, 4);
    chk("t4_mid_err", err, 1);
    beat(0, 1, 6);
    chk("t4_err_pulse", err, 0);
    chk("t4_val", sum_val, 1);
    chk("t4_sum", sum, 10);
    chk("t4_len", len, 2);
    idle(1);

    // 5: saturation on the MAX_WORDS=4 instance
    beat4(1, 0, 16);
    for (int i = 0; i < 4; i++) beat4(0, 0, 16);
    beat4(0, 1, 16);
    chk("t5_val", sum_val4, 1);
    chk("t5_sum", sum4, 64);
    chk("t5_len", len4, 4);
    chk("t5_sat", sat4, 1);
    beat4(1, 1, 2);
    chk("t5_next_sum", sum4, 2);
    chk("t5_sat_clear", sat4, 0);

    // 6: async reset mid-packet
    ready = 1'b0;
    beat(1, 1, 5);
    chk("t6_pre_val", sum_val, 1);
    beat(1, 0, 9);
    beat(0, 0, 9);
    #2 arst_n = 1'b0;
    #1;
    chk("t6_rst_val", sum_val, 0);
    chk("t6_rst_sum", sum, 0);
    chk("t6_rst_len", len, 0);
    @(negedge clk);
    arst_n = 1'b1;
    ready = 1'b1;
    beat(1, 0, 3);
    beat(0, 1, 3);
    chk("t6_err", err, 0);
    chk("t6_val", sum_val, 1);
    chk("t6_sum", sum, 6);
    chk("t6_len", len, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
